ctrl_pipe_chain: RTL and testbench

Parametrised control-pipeline register chain that carries decoded control words from decode through STAGES downstream pipeline registers (E, M, W, … for the default 4). Each stage has its own stall and flush, a valid bit, and a delay-slot flag that travels with the instruction. Stall propagates upstream, and a bubble is inserted below a held stage. A built-in multi-cycle hold counter freezes one stage (divider/multiplier use) for a programmable number of cycles. It replaces per-stage hand-wired enable/clear flops in the controller.

---
 rtl/ctrl_pipe_pkg.sv | 12 +
 rtl/ctrl_pipe_stage.sv | 16 +
 rtl/ctrl_pipe_chain.sv | 61 ++++++
 tb/tb_ctrl_pipe_chain.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pipe_pkg: shared defaults, control-word field offsets and stage indices for the control pipeline
package ctrl_pipe_pkg;
  localparam int STAGES_DEF = 4;
  localparam int WIDTH_DEF = 19;
  localparam int F_REG_WRITE = 0;
  localparam int F_MEM_READ = 1;
  localparam int F_MEM_WRITE = 2;
  localparam int F_RET_SRC = 3;
  localparam int F_CP0_WRITE = 5;
  localparam int F_ALU_OP = 6;
  typedef enum logic [1:0] {ST_E, ST_M, ST_W} stage_e;
endpackage

// File: rtl/ctrl_pipe_stage.sv
// ctrl_pipe_stage: one pipeline register with flush > hold > bubble > load priority
module ctrl_pipe_stage import ctrl_pipe_pkg::*; #(
  parameter int W = WIDTH_DEF + 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         hold,
  input  logic         bubble,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (rst || flush || (!hold && bubble)) q <= '0;
    else if (!hold) q <= d;
endmodule

// File: rtl/ctrl_pipe_chain.sv
// ctrl_pipe_chain: decoded control words through STAGES registers with stall/flush, delay-slot tagging and a multi-cycle hold
module ctrl_pipe_chain import ctrl_pipe_pkg::*; #(
  parameter int STAGES = STAGES_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter bit COLLAPSE = 1'b0,
  parameter int MC_STAGE = int'(ST_E),
  parameter int CNTW = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        in_ctrl,
  input  logic                    in_valid,
  input  logic                    in_branch,
  output logic                    in_ready,
  input  logic [STAGES-1:0]       stall,
  input  logic [STAGES-1:0]       flush,
  input  logic                    mc_start,
  input  logic [CNTW-1:0]         mc_len,
  output logic                    mc_busy,
  output logic [STAGES*WIDTH-1:0] out_ctrl,
  output logic [STAGES-1:0]       out_valid,
  output logic [STAGES-1:0]       out_ds
);
  logic [STAGES-1:0] req, hold, bubble;
  logic [STAGES-1:0][WIDTH+1:0] st, din;
  logic [CNTW-1:0] cnt;
  logic dsPending, mcGo, mcHold;
  assign mc_busy = cnt != '0;
  assign mcGo = mc_start & out_valid[MC_STAGE] & ~mc_busy & (mc_len != '0);
  assign mcHold = mc_busy | mcGo;
  assign in_ready = ~hold[0];
  assign bubble = hold << 1;
  // hold ripples upward from the last stage; with COLLAPSE an empty stage absorbs it
  always_comb begin
    req = stall;
    req[MC_STAGE] = stall[MC_STAGE] | mcHold;
    hold = req;
    for (int i = STAGES - 2; i >= 0; i--)
      hold[i] = req[i] | (hold[i+1] & (COLLAPSE ? out_valid[i] : 1'b1));
  end
  always_comb begin
    din = st << (WIDTH + 2);
    din[0] = {in_ctrl & {WIDTH{in_valid}}, in_valid, dsPending & in_valid};
  end
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    ctrl_pipe_stage #(.W(WIDTH + 2)) u_stage (
      .clk(clk), .rst(rst), .flush(flush[i]), .hold(hold[i]),
      .bubble(bubble[i]), .d(din[i]), .q(st[i])
    );
    assign out_ctrl[i*WIDTH +: WIDTH] = st[i][WIDTH+1:2];
    assign out_valid[i] = st[i][1];
    assign out_ds[i] = st[i][0];
  end
  always_ff @(posedge clk)
    if (rst || flush[0]) dsPending <= 1'b0;
    else if (in_ready && in_valid) dsPending <= in_branch;
  always_ff @(posedge clk)
    if (rst || flush[MC_STAGE]) cnt <= '0;
    else if (mcGo) cnt <= mc_len - 1'b1;
    else if (mc_busy) cnt <= cnt - 1'b1;
endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// tb_ctrl_pipe_chain: directed stimulus with a scoreboard on the last stage plus cycle-exact stage checks
module tb_ctrl_pipe_chain;
  localparam int S = 4;
  localparam int W = 19;
  localparam int CW = 6;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [W-1:0] in_ctrl = '0;
  logic in_valid = 1'b0, in_branch = 1'b0, mc_start = 1'b0;
  logic [S-1:0] stall = '0, flush = '0;
  logic [CW-1:0] mc_len = '0;
  logic in_ready, mc_busy, in_ready_c, mc_busy_c;
  logic [S*W-1:0] out_ctrl, out_ctrl_c;
  logic [S-1:0] out_valid, out_ds, out_valid_c, out_ds_c;
  int total = 0;
  int bad = 0;
  logic [W:0] sb[$];

  always #5 clk = ~clk;

  ctrl_pipe_chain #(.STAGES(S), .WIDTH(W), .COLLAPSE(1'b0), .MC_STAGE(0), .CNTW(CW)) dut (
    .clk(clk), .rst(rst), .in_ctrl(in_ctrl), .in_valid(in_valid), .in_branch(in_branch),
    .in_ready(in_ready), .stall(stall), .flush(flush), .mc_start(mc_start), .mc_len(mc_len),
    .mc_busy(mc_busy), .out_ctrl(out_ctrl), .out_valid(out_valid), .out_ds(out_ds)
  );

  ctrl_pipe_chain #(.STAGES(S), .WIDTH(W), .COLLAPSE(1'b1), .MC_STAGE(0), .CNTW(CW)) dutc (
    .clk(clk), .rst(rst), .in_ctrl(in_ctrl), .in_valid(in_valid), .in_branch(in_branch),
    .in_ready(in_ready_c), .stall(stall), .flush(flush), .mc_start(mc_start), .mc_len(mc_len),
    .mc_busy(mc_busy_c), .out_ctrl(out_ctrl_c), .out_valid(out_valid_c), .out_ds(out_ds_c)
  );

  function automatic logic [W-1:0] oc(int i);
    return out_ctrl[i*W +: W];
  endfunction

  function automatic logic [W-1:0] occ(int i);
    return out_ctrl_c[i*W +: W];
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [W-1:0] c, logic br, logic ds, logic push);
    in_ctrl = c;
    in_valid = 1'b1;
    in_branch = br;
    if (push) sb.push_back({c, ds});
  endtask

  // every valid word leaving the last stage must match the next expected one in order
  initial begin
    logic [W:0] e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid[S-1]) begin
        e = (sb.size() != 0) ? sb.pop_front() : '1;
        chk("sb_out", 32'({oc(S-1), out_ds[S-1]}), 32'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1);
  end

  initial begin
    repeat (2) step();
    rst = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ctrl", 32'(|out_ctrl), 0);
    chk("rst_ds", 32'(out_ds), 0);
    chk("rst_busy", 32'(mc_busy), 0);
    chk("rst_ready", 32'(in_ready), 1);
    // single word through all stages
    send(19'h1A5, 1'b0, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    chk("t1_s0", 32'(oc(0)), 32'h1A5);
    chk("t1_v0", 32'(out_valid), 32'b0001);
    repeat (3) step();
    chk("t1_s3", 32'(oc(3)), 32'h1A5);
    chk("t1_v3", 32'(out_valid), 32'b1000);
    step();
    // stall[1] for two cycles in a stream
    send(19'h00A, 1'b0, 1'b0, 1'b1); step();
    send(19'h00B, 1'b0, 1'b0, 1'b1); step();
    send(19'h00C, 1'b0, 1'b0, 1'b1); step();
    send(19'h00D, 1'b0, 1'b0, 1'b1);
    stall = 4'b0010;
    #1;
    chk("t2_rdy", 32'(in_ready), 0);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("t2_s0", 32'(oc(0)), 32'h00C);
      chk("t2_s1", 32'(oc(1)), 32'h00B);
      chk("t2_v2", 32'(out_valid[2]), 0);
      chk("t2_c2", 32'(oc(2)), 0);
      chk("t2_rdy_hold", 32'(in_ready), 0);
    end
    stall = '0;
    #1;
    chk("t2_rdy_rel", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
    chk("t2_r0", 32'(oc(0)), 32'h00D);
    chk("t2_r1", 32'(oc(1)), 32'h00C);
    chk("t2_r2", 32'(oc(2)), 32'h00B);
    repeat (4) step();
    // delay slot tag follows the instruction after a branch
    send(19'h011, 1'b1, 1'b0, 1'b1); step();
    send(19'h00E, 1'b0, 1'b1, 1'b1); step();
    in_valid = 1'b0;
    in_branch = 1'b0;
    chk("t3_ds0", 32'(out_ds), 32'b0001);
    for (int k = 1; k < S; k++) begin
      step();
      chk("t3_ds", 32'(out_ds), 32'(4'b0001 << k));
    end
    step();
    // flush[0] on the delay-slot cycle clears it and the pending flag
    send(19'h012, 1'b1, 1'b0, 1'b1); step();
    send(19'h00F, 1'b0, 1'b0, 1'b0);
    flush = 4'b0001;
    #1;
    chk("t3_rdy_fl", 32'(in_ready), 1);
    step();
    flush = '0;
    chk("t3_fl_v0", 32'(out_valid[0]), 0);
    chk("t3_fl_c0", 32'(oc(0)), 0);
    send(19'h010, 1'b0, 1'b0, 1'b1); step();
    in_valid = 1'b0;
    chk("t3_ds_clr", 32'(out_ds[0]), 0);
    repeat (5) step();
    // multi-cycle hold of 3 in stage 0
    send(19'h0A0, 1'b0, 1'b0, 1'b1); step();
    in_valid = 1'b0;
    mc_len = 6'd3;
    mc_start = 1'b1;
    #1;
    chk("t4_rdy_start", 32'(in_ready), 0);
    chk("t4_busy_start", 32'(mc_busy), 0);
    step();
    mc_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("t4_busy", 32'(mc_busy), 1);
      chk("t4_rdy", 32'(in_ready), 0);
      chk("t4_s0", 32'(oc(0)), 32'h0A0);
      chk("t4_v1", 32'(out_valid[1]), 0);
      step();
    end
    chk("t4_busy_end", 32'(mc_busy), 0);
    chk("t4_rdy_end", 32'(in_ready), 1);
    chk("t4_s0_end", 32'(oc(0)), 32'h0A0);
    chk("t4_v1_end", 32'(out_valid[1]), 0);
    step();
    chk("t4_s1", 32'(oc(1)), 32'h0A0);
    chk("t4_v0", 32'(out_valid[0]), 0);
    repeat (4) step();
    // zero length request is ignored
    send(19'h0B0, 1'b0, 1'b0, 1'b1); step();
    in_valid = 1'b0;
    mc_len = 6'd0;
    mc_start = 1'b1;
    #1;
    chk("t4_len0_rdy", 32'(in_ready), 1);
    step();
    mc_start = 1'b0;
    chk("t4_len0_busy", 32'(mc_busy), 0);
    chk("t4_len0_s1", 32'(oc(1)), 32'h0B0);
    repeat (4) step();
    // flush and stall on stage 2 together
    send(19'h0C1, 1'b0, 1'b0, 1'b0); step();
    send(19'h0C2, 1'b0, 1'b0, 1'b1); step();
    send(19'h0C3, 1'b0, 1'b0, 1'b1); step();
    in_valid = 1'b0;
    stall = 4'b0100;
    flush = 4'b0100;
    step();
    flush = '0;
    chk("t5_v2", 32'(out_valid[2]), 0);
    chk("t5_c2", 32'(oc(2)), 0);
    chk("t5_s0", 32'(oc(0)), 32'h0C3);
    chk("t5_s1", 32'(oc(1)), 32'h0C2);
    chk("t5_rdy", 32'(in_ready), 0);
    stall = '0;
    repeat (5) step();
    // empty stage 1 absorbs the stall only with COLLAPSE
    send(19'h0D1, 1'b0, 1'b0, 1'b1); step();
    in_valid = 1'b0;
    stall = 4'b0100;
    #1;
    chk("t6_rdy", 32'(in_ready), 0);
    chk("t6_rdy_c", 32'(in_ready_c), 1);
    step();
    chk("t6_s0", 32'(oc(0)), 32'h0D1);
    chk("t6_c_s1", 32'(occ(1)), 32'h0D1);
    chk("t6_c_v1", 32'(out_valid_c[1]), 1);
    chk("t6_c_v0", 32'(out_valid_c[0]), 0);
    stall = '0;
    repeat (6) step();
    chk("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
